pipe_stage_skid: RTL and testbench

- Parametrised pipeline-stage register, the successor to the fixed EX/MEM latch.
- Carries a generic payload plus write-back register number and write enable between any two pipeline stages.
- Adds a valid/ready handshake, synchronous flush (bubble injection) and an optional 2-entry skid buffer, so upstream ready is registered.
- Exports hazard-detection info for every occupied entry so the hazard unit sees in-flight writers, including stalled ones.

---
 rtl/pipe_stage_skid.sv | 175 +++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
//------------------------------------------------------------------------------
// Module   : pipe_stage_skid
// Brief    : Parametrised valid/ready pipeline stage with flush and an
//            optional 2-entry skid buffer; exports hazard info per entry.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_skid #(
    parameter int DATA_W  = 96,
    parameter int RADDR_W = 5,
    parameter int SKID    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [RADDR_W-1:0] in_wr,
    input  logic               in_we,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [RADDR_W-1:0] out_wr,
    output logic               out_we,
    output logic [RADDR_W-1:0] haz_wr0,
    output logic               haz_we0,
    output logic [RADDR_W-1:0] haz_wr1,
    output logic               haz_we1,
    output logic [1:0]         occ
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [DATA_W-1:0]    r_head_data;
    logic [RADDR_W-1:0]   r_head_wr;
    logic                 r_head_we;
    logic [DATA_W-1:0]    r_skid_data;
    logic [RADDR_W-1:0]   r_skid_wr;
    logic                 r_skid_we;

    logic                 r_out_valid;
    logic                 r_out_we;
    logic                 r_haz_we1;
    logic [1:0]           r_occ;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_drain;
    logic                 w_load_head_in;
    logic                 w_load_head_skid;
    logic                 w_load_skid;
    logic                 w_head_we_nxt;
    logic                 w_skid_we_nxt;

    // Upstream ready: registered-state decode with a skid entry, otherwise
    // the classic combinational pass-through of downstream ready.
    if (SKID != 0) begin : g_skid_ready
        assign w_in_ready = !rst && (r_state != ST_TWO);
    end else begin : g_flow_ready
        assign w_in_ready = !rst && (!r_out_valid || out_ready);
    end

    assign w_accept = in_valid && w_in_ready;
    assign w_drain  = r_out_valid && out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ST_ONE;
                        w_load_head_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_head_in = 1'b1;
                    end else if (w_accept) begin
                        // Unreachable without a skid entry: in_ready is low
                        // whenever the head is stuck.
                        if (SKID != 0) begin
                            w_state_nxt = ST_TWO;
                            w_load_skid = 1'b1;
                        end
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_drain) begin
                        w_state_nxt      = ST_ONE;
                        w_load_head_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    assign w_head_we_nxt = w_load_head_in   ? in_we     :
                           w_load_head_skid ? r_skid_we : r_head_we;
    assign w_skid_we_nxt = w_load_skid ? in_we : r_skid_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_head_data <= '0;
            r_head_wr   <= '0;
            r_head_we   <= 1'b0;
            r_skid_data <= '0;
            r_skid_wr   <= '0;
            r_skid_we   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_we    <= 1'b0;
            r_haz_we1   <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_head_in) begin
                r_head_data <= in_data;
                r_head_wr   <= in_wr;
                r_head_we   <= in_we;
            end else if (w_load_head_skid) begin
                r_head_data <= r_skid_data;
                r_head_wr   <= r_skid_wr;
                r_head_we   <= r_skid_we;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_wr   <= in_wr;
                r_skid_we   <= in_we;
            end
            // Valid-gated enables are precomputed so every output is a flop.
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_out_we    <= (w_state_nxt != ST_EMPTY) && w_head_we_nxt;
            r_haz_we1   <= (w_state_nxt == ST_TWO) && w_skid_we_nxt;
            case (w_state_nxt)
                ST_ONE:  r_occ <= 2'd1;
                ST_TWO:  r_occ <= 2'd2;
                default: r_occ <= 2'd0;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_head_data;
    assign out_wr    = r_head_wr;
    assign out_we    = r_out_we;
    assign haz_wr0   = r_head_wr;
    assign haz_we0   = r_out_we;
    assign haz_wr1   = r_skid_wr;
    assign haz_we1   = r_haz_we1;
    assign occ       = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
//------------------------------------------------------------------------------
// Module   : tb_pipe_stage_skid
// Brief    : Directed self-checking bench for pipe_stage_skid (SKID=1 and 0).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_skid;

    localparam int DATA_W  = 96;
    localparam int RADDR_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // SKID=1 instance
    logic               a_in_valid = 1'b0, a_in_ready, a_in_we = 1'b0, a_flush = 1'b0;
    logic [DATA_W-1:0]  a_in_data = '0, a_out_data;
    logic [RADDR_W-1:0] a_in_wr = '0, a_out_wr, a_haz_wr0, a_haz_wr1;
    logic               a_out_valid, a_out_ready = 1'b0, a_out_we;
    logic               a_haz_we0, a_haz_we1;
    logic [1:0]         a_occ;

    // SKID=0 instance
    logic               b_in_valid = 1'b0, b_in_ready, b_in_we = 1'b0, b_flush = 1'b0;
    logic [DATA_W-1:0]  b_in_data = '0, b_out_data;
    logic [RADDR_W-1:0] b_in_wr = '0, b_out_wr, b_haz_wr0, b_haz_wr1;
    logic               b_out_valid, b_out_ready = 1'b0, b_out_we;
    logic               b_haz_we0, b_haz_we1;
    logic [1:0]         b_occ;

    pipe_stage_skid #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .SKID(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_wr(a_in_wr), .in_we(a_in_we), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_wr(a_out_wr), .out_we(a_out_we),
        .haz_wr0(a_haz_wr0), .haz_we0(a_haz_we0),
        .haz_wr1(a_haz_wr1), .haz_we1(a_haz_we1), .occ(a_occ)
    );

    pipe_stage_skid #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .SKID(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_wr(b_in_wr), .in_we(b_in_we), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_wr(b_out_wr), .out_we(b_out_we),
        .haz_wr0(b_haz_wr0), .haz_we0(b_haz_we0),
        .haz_wr1(b_haz_wr1), .haz_we1(b_haz_we1), .occ(b_occ)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [DATA_W-1:0] d,
                           input logic [RADDR_W-1:0] wr, input logic we);
        a_in_valid = v;
        a_in_data  = d;
        a_in_wr    = wr;
        a_in_we    = we;
    endtask

    // SKID=0 toggle table: out_ready per cycle, expected in_ready and head data.
    logic [5:0]  tg_ordy = 6'b010101;
    logic [7:0]  tg_out [6] = '{8'h51, 8'h61, 8'h61, 8'h62, 8'h62, 8'h63};

    initial begin
        // Reset held two cycles with upstream pushing.
        rst = 1'b1;
        a_drive(1'b1, 96'h77, 5'd7, 1'b1);
        step();
        step();
        check_eq("rst_in_ready", a_in_ready, 1'b0);
        check_eq("rst_out_valid", a_out_valid, 1'b0);
        check_eq("rst_occ", a_occ, 2'd0);
        check_eq("rst_out_we", a_out_we, 1'b0);
        check_eq("rst_haz_we0", a_haz_we0, 1'b0);
        check_eq("rst_haz_we1", a_haz_we1, 1'b0);
        check_eq("rst_b_in_ready", b_in_ready, 1'b0);

        // First accept after release, visible one cycle later.
        rst = 1'b0;
        a_out_ready = 1'b0;
        a_drive(1'b1, 96'hAA, 5'd3, 1'b1);
        #1;
        check_eq("rel_in_ready", a_in_ready, 1'b1);
        step();
        check_eq("rel_out_valid", a_out_valid, 1'b1);
        check_eq("rel_out_data", a_out_data, 96'hAA);
        check_eq("rel_out_wr", a_out_wr, 5'd3);
        check_eq("rel_occ", a_occ, 2'd1);
        a_drive(1'b0, '0, '0, 1'b0);
        a_out_ready = 1'b1;
        step();
        check_eq("rel_drained", a_out_valid, 1'b0);

        // Streaming with out_ready held high.
        for (int i = 1; i <= 8; i++) begin
            a_drive(1'b1, 96'(i), 5'(i), 1'b1);
            #1;
            check_eq("str_in_ready", a_in_ready, 1'b1);
            if (i > 1) begin
                check_eq("str_out_valid", a_out_valid, 1'b1);
                check_eq("str_out_data", a_out_data, 96'(i - 1));
                check_eq("str_out_wr", a_out_wr, 5'(i - 1));
            end
            step();
        end
        a_drive(1'b0, '0, '0, 1'b0);
        check_eq("str_last_data", a_out_data, 96'd8);
        check_eq("str_last_valid", a_out_valid, 1'b1);
        step();
        check_eq("str_empty", a_out_valid, 1'b0);

        // Backpressure fills the skid entry.
        a_out_ready = 1'b0;
        a_drive(1'b1, 96'hA, 5'd10, 1'b1);
        step();
        check_eq("bp_occ1", a_occ, 2'd1);
        check_eq("bp_ready1", a_in_ready, 1'b1);
        a_drive(1'b1, 96'hB, 5'd11, 1'b1);
        step();
        a_drive(1'b0, '0, '0, 1'b0);
        check_eq("bp_occ2", a_occ, 2'd2);
        check_eq("bp_ready2", a_in_ready, 1'b0);
        check_eq("bp_haz_wr0", a_haz_wr0, 5'd10);
        check_eq("bp_haz_wr1", a_haz_wr1, 5'd11);
        check_eq("bp_haz_we0", a_haz_we0, 1'b1);
        check_eq("bp_haz_we1", a_haz_we1, 1'b1);
        check_eq("bp_head", a_out_data, 96'hA);
        a_out_ready = 1'b1;
        #1;
        check_eq("bp_ready_no_comb", a_in_ready, 1'b0);
        step();
        check_eq("bp_out_b", a_out_data, 96'hB);
        check_eq("bp_occ_after_a", a_occ, 2'd1);
        check_eq("bp_ready_back", a_in_ready, 1'b1);
        check_eq("bp_haz_we1_clr", a_haz_we1, 1'b0);
        step();
        check_eq("bp_drained", a_out_valid, 1'b0);

        // Flush while two beats are held.
        a_out_ready = 1'b0;
        a_drive(1'b1, 96'hC1, 5'd5, 1'b1);
        step();
        a_drive(1'b1, 96'hC2, 5'd6, 1'b1);
        step();
        a_drive(1'b0, '0, '0, 1'b0);
        check_eq("fl2_occ_pre", a_occ, 2'd2);
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        check_eq("fl2_out_valid", a_out_valid, 1'b0);
        check_eq("fl2_occ", a_occ, 2'd0);
        check_eq("fl2_haz_we0", a_haz_we0, 1'b0);
        check_eq("fl2_haz_we1", a_haz_we1, 1'b0);
        check_eq("fl2_in_ready", a_in_ready, 1'b1);
        a_out_ready = 1'b1;
        step();
        check_eq("fl2_no_replay", a_out_valid, 1'b0);

        // Flush coincident with accept while empty.
        a_drive(1'b1, 96'hD, 5'd9, 1'b1);
        a_flush = 1'b1;
        #1;
        check_eq("flc_handshake", a_in_ready, 1'b1);
        step();
        a_flush = 1'b0;
        a_drive(1'b0, '0, '0, 1'b0);
        check_eq("flc_out_valid", a_out_valid, 1'b0);
        check_eq("flc_out_we", a_out_we, 1'b0);

        // Flush coincident with drain.
        a_out_ready = 1'b0;
        a_drive(1'b1, 96'hE1, 5'd12, 1'b1);
        step();
        a_drive(1'b0, '0, '0, 1'b0);
        check_eq("fld_held", a_out_data, 96'hE1);
        a_out_ready = 1'b1;
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        check_eq("fld_gone", a_out_valid, 1'b0);
        step();
        check_eq("fld_not_again", a_out_valid, 1'b0);

        // A beat without write enable never asserts the write-enable outputs.
        a_drive(1'b1, 96'hF0, 5'd13, 1'b0);
        a_out_ready = 1'b0;
        step();
        a_drive(1'b0, '0, '0, 1'b0);
        check_eq("nowe_valid", a_out_valid, 1'b1);
        check_eq("nowe_out_we", a_out_we, 1'b0);
        check_eq("nowe_haz_we0", a_haz_we0, 1'b0);
        a_out_ready = 1'b1;
        step();

        // SKID=0: ready follows out_ready combinationally.
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 96'h51;
        b_in_wr     = 5'd1;
        b_in_we     = 1'b1;
        step();
        b_in_data = 96'h61;
        b_in_wr   = 5'd2;
        #1;
        check_eq("s0_occ1", b_occ, 2'd1);
        check_eq("s0_ready_low", b_in_ready, 1'b0);
        check_eq("s0_haz_we1", b_haz_we1, 1'b0);
        for (int c = 0; c < 6; c++) begin
            b_out_ready = tg_ordy[c];
            #1;
            check_eq("s0_tog_ready", b_in_ready, tg_ordy[c]);
            check_eq("s0_tog_data", b_out_data, 96'(tg_out[c]));
            check_eq("s0_tog_occ", b_occ <= 2'd1, 1'b1);
            step();
            if (tg_ordy[c]) begin
                b_in_data = b_in_data + 96'd1;
                b_in_wr   = b_in_wr + 5'd1;
            end
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        step();
        check_eq("s0_drained", b_out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
